// File: rtl/iomem_dma.sv
// iomem_dma: single-channel word-copy engine with an iomem config responder and a bus initiator.
// Build option: define IOMEM_DMA_TRIGGER_EN to let a rising edge on trigger start a transfer.
module iomem_dma (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        trigger,
    output logic        done
);
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RGAP, S_WR, S_WGAP} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   src, dst, data;
    logic [CW-1:0]   count;
    logic            aborted, abort_pend, trig_en, trig_start;
    logic            done_set, abort_set;
    logic            m_valid_d;
    logic [3:0]      m_wstrb_d;
    logic [AW-1:0]   m_addr_d, m_wdata_d;
    logic [AW-1:0]   src_wr, dst_wr, rd_val;
    logic [CW-1:0]   count_wr;
    logic [1:0]      sel;
    logic            busy, cfg_access, cfg_wr, ctrl_wr;
    logic            start_req, abort_req, done_clr, aborted_clr, rd_hs, wr_hs;
    logic            unused_addr;

    function automatic logic [AW-1:0] merge32(input logic [AW-1:0] old, input logic [AW-1:0] wd,
                                              input logic [3:0] be);
        logic [AW-1:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = be[i] ? wd[i*8 +: 8] : old[i*8 +: 8];
        return r;
    endfunction

    assign sel         = iomem_addr[3:2];
    assign unused_addr = ^{iomem_addr[31:4], iomem_addr[1:0]};
    assign busy        = (state != S_IDLE);
    assign cfg_access  = iomem_valid && !iomem_ready;
    assign cfg_wr      = cfg_access && (iomem_wstrb != 4'd0);
    assign ctrl_wr     = cfg_wr && (sel == 2'd3) && iomem_wstrb[0];
    assign start_req   = (ctrl_wr && iomem_wdata[0]) || trig_start;
    assign abort_req   = ctrl_wr && iomem_wdata[4];
    assign done_clr    = ctrl_wr && iomem_wdata[2];
    assign aborted_clr = ctrl_wr && iomem_wdata[5];
    assign rd_hs       = (state == S_RD) && m_ready;
    assign wr_hs       = (state == S_WR) && m_ready;
    assign src_wr      = merge32(src, iomem_wdata, iomem_wstrb);
    assign dst_wr      = merge32(dst, iomem_wdata, iomem_wstrb);
    assign count_wr    = {iomem_wstrb[1] ? iomem_wdata[15:8] : count[15:8],
                          iomem_wstrb[0] ? iomem_wdata[7:0]  : count[7:0]};

    always_comb begin : rd_mux
        rd_val = '0;
        case (sel)
            2'd0:    rd_val = src;
            2'd1:    rd_val = dst;
            2'd2:    rd_val = AW'(count);
            default: rd_val = AW'({aborted, 1'b0, trig_en, done, busy, 1'b0});
        endcase
    end

`ifdef IOMEM_DMA_TRIGGER_EN
    logic trig_q;

    // Trigger edge detector and the trig_en control bit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            trig_q  <= 1'b0;
            trig_en <= 1'b0;
        end else begin
            trig_q <= trigger;
            if (ctrl_wr) trig_en <= iomem_wdata[3];
        end
    end
    assign trig_start = trig_en && trigger && !trig_q;
`else
    logic unused_trigger;
    assign unused_trigger = trigger;
    assign trig_en        = 1'b0;
    assign trig_start     = 1'b0;
`endif

    // State register; bus outputs are registered from the next state
    always_ff @(posedge clk) begin : state_reg
        if (!resetn) begin
            state   <= S_IDLE;
            m_valid <= 1'b0;
            m_wstrb <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            state   <= state_nx;
            m_valid <= m_valid_d;
            m_wstrb <= m_wstrb_d;
            m_addr  <= m_addr_d;
            m_wdata <= m_wdata_d;
        end
    end

    // An abort lets the in-flight beat finish, then returns to idle
    always_comb begin : next_state_comb
        state_nx  = state;
        done_set  = 1'b0;
        abort_set = 1'b0;
        case (state)
            S_IDLE: if (start_req) begin
                if (count != CW'(0)) state_nx = S_RD;
                else                 done_set = 1'b1;
            end
            S_RD:   if (m_ready) state_nx = abort_pend ? S_IDLE : S_RGAP;
            S_RGAP: state_nx = abort_pend ? S_IDLE : S_WR;
            S_WR:   if (m_ready) state_nx = abort_pend ? S_IDLE : S_WGAP;
            S_WGAP: begin
                if (abort_pend) begin
                    state_nx = S_IDLE;
                end else if (count == CW'(0)) begin
                    state_nx = S_IDLE;
                    done_set = 1'b1;
                end else begin
                    state_nx = S_RD;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        abort_set = abort_pend && busy && (state_nx == S_IDLE);
    end

    always_comb begin : output_comb
        m_valid_d = 1'b0;
        m_wstrb_d = 4'd0;
        m_addr_d  = m_addr;
        m_wdata_d = m_wdata;
        case (state_nx)
            S_RD: begin
                m_valid_d = 1'b1;
                m_addr_d  = src;
            end
            S_WR: begin
                m_valid_d = 1'b1;
                m_wstrb_d = 4'hF;
                m_addr_d  = dst;
                m_wdata_d = data;
            end
            default: ;
        endcase
    end

    // Config registers, responder handshake and working pointers
    always_ff @(posedge clk) begin : regs
        if (!resetn) begin
            src         <= '0;
            dst         <= '0;
            count       <= '0;
            data        <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            abort_pend  <= 1'b0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= cfg_access;
            if (cfg_access) iomem_rdata <= rd_val;
            if (cfg_wr && !busy) begin
                case (sel)
                    2'd0:    src   <= {src_wr[AW-1:2], 2'b00};
                    2'd1:    dst   <= {dst_wr[AW-1:2], 2'b00};
                    2'd2:    count <= count_wr;
                    default: ;
                endcase
            end
            if (rd_hs) data <= m_rdata;
            if (wr_hs) begin
                src   <= src + AW'(4);
                dst   <= dst + AW'(4);
                count <= count - CW'(1);
            end
            if (done_clr)    done    <= 1'b0;
            if (done_set)    done    <= 1'b1;
            if (aborted_clr) aborted <= 1'b0;
            if (abort_set)   aborted <= 1'b1;
            abort_pend <= busy && (state_nx != S_IDLE) && (abort_pend || abort_req);
        end
    end
endmodule
